irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Interrupt-request front end for the 4-input priority encoder stage.
- Captures rising edges on raw request lines into sticky pending bits and applies an enable mask.
- Presents a frozen, masked pending vector to the downstream encoder with a valid/ack handshake.
- Clears the serviced source on acknowledge, so the encoder always sees a stable vector of outstanding requests.

Parameters:
- N_SRC, 4, number of request sources; must match encoder input width.
- IDX_W, $clog2(N_SRC) = 2, width of the acknowledged-source index.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- irq_in  input  N_SRC  raw request lines, already synchronous to clk.
- irq_mask  input  N_SRC  per-source enable; 1 = enabled.
- irq_ack  input  1  one-cycle pulse: the source at ack_idx has been serviced.
- ack_idx  input  IDX_W  index being acknowledged; this is the encoder output.
- irq_vec  output  N_SRC  frozen masked pending snapshot; drives the encoder data input.
- irq_valid  output  1  irq_vec holds at least one request and is stable.
- pend  output  N_SRC  live sticky pending register, unmasked, for status.
- ack_err  output  1  one-cycle pulse: illegal acknowledge.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low. All flops update on the rising edge of `clk`.
- Reset values:
  - irq_vec=0, irq_valid=0, pend=0, ack_err=0, state=IDLE.
  - prev_in resets to all-ones, so lines already high at reset release do not register an edge.
- Edge detect:
  - rise[i] = irq_in[i] & ~prev_in[i]; prev_in <= irq_in every cycle.
  - rise[i] sets pend[i] on the next edge.
  - A rise is captured regardless of mask. The mask gates presentation only, not capture.
- Masked vector: mpend = pend & irq_mask (combinational, internal).
- FSM states:
  - IDLE: irq_valid=0. If mpend != 0, load irq_vec <= mpend and go to REQ.
  - REQ: irq_valid=1; irq_vec held constant. On irq_ack, process the ack and go to GAP.
  - GAP: one cycle, irq_valid=0, irq_vec=0 (downstream settle / deassert window). Then go to IDLE.
- Latency:
  - Edge on irq_in at cycle t → pend set at t+1 → REQ with irq_valid=1 at t+2 (if masked-in and FSM idle).
  - Minimum back-to-back service: 3 cycles per request (REQ, GAP, IDLE).
- Acknowledge processing (REQ only):
  - Legal if ack_idx < N_SRC and irq_vec[ack_idx]=1. Clear pend[ack_idx] on the same edge as the REQ→GAP transition.
  - Otherwise: no clear, ack_err pulses for 1 cycle, FSM still goes to GAP. The request is re-presented on the next pass.
  - irq_ack in IDLE or GAP: ignored, ack_err=1 for 1 cycle.
- Simultaneous events:
  - rise[i] in the same cycle as a clear of pend[i]: set wins, pend[i]=1. The new event is not lost.
  - New rises or mask changes during REQ: update pend, but irq_vec stays frozen until the next IDLE load.
  - Mask cleared for a pending source: the bit stays in pend and is not presented until unmasked.
- Reset mid-operation: rst_n low in any state forces reset values on the next edge. Pending requests are discarded.
- Widths: ack_idx compared after zero-extension; no wrap. Out-of-range values are possible only when N_SRC is not a power of 2.

Decomposition:
- Package irq_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t.
  - localparam N_SRC_DEF = 4.
- Sub-module edge_capture: prev_in register, rise generation, and sticky pend with set-over-clear priority. Instantiated once, N_SRC wide.
- The FSM and handshake stay in irq_pending_ctrl.

Test Plan:
- Reset with irq_in=4'b0110 held, release, hold 5 cycles → pend=0, irq_valid=0 throughout (no false edge).
- irq_mask=4'b1111, pulse irq_in[2] at cycle t → irq_valid=1 with irq_vec=4'b0100 at t+2; ack ack_idx=2 → pend=0, GAP, then IDLE, irq_valid=0.
- Rise on sources 3 and 0 together → irq_vec=4'b1001. Ack idx 3 → re-present irq_vec=4'b0001 two cycles later. Ack idx 0 → pend=0.
- During REQ with irq_vec=4'b0100, ack idx 1 → ack_err pulse, pend unchanged, irq_vec=4'b0100 re-presented after GAP.
- irq_mask=4'b0111, rise on source 3 → pend=4'b1000, irq_valid stays 0. Set mask bit 3 → irq_valid=1, irq_vec=4'b1000 two cycles later.
- Rise on source 1 on the same cycle as a legal ack of idx 1 → pend[1] stays 1, re-presented; assert rst_n=0 during REQ → all outputs 0 next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt pending/presentation front end.
package irq_pkg;

  localparam int unsigned N_SRC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_t;

  // Index width that stays at least one bit for a single-source build.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request/encoder-side signal bundle for irq_pending_ctrl.
interface irq_pending_ctrl_if
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned IDX_W = idx_width(N_SRC)
);

  logic [N_SRC-1:0] irq_in;
  logic [N_SRC-1:0] irq_mask;
  logic             irq_ack;
  logic [IDX_W-1:0] ack_idx;
  logic [N_SRC-1:0] irq_vec;
  logic             irq_valid;
  logic [N_SRC-1:0] pend;
  logic             ack_err;

  modport master (
    output irq_in, irq_mask, irq_ack, ack_idx,
    input  irq_vec, irq_valid, pend, ack_err
  );

  modport slave (
    input  irq_in, irq_mask, irq_ack, ack_idx,
    output irq_vec, irq_valid, pend, ack_err
  );

endinterface

// File: rtl/edge_capture.sv
// Rising-edge detection on raw request lines into sticky pending bits.
module edge_capture
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] clr,
  output logic [N_SRC-1:0] pend
);

  logic [N_SRC-1:0] prev_in;
  logic [N_SRC-1:0] rise;

  assign rise = irq_in & ~prev_in;

  // prev_in resets high so lines already asserted at reset release are not edges.
  // A new rise overrides a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_in <= '1;
      pend    <= '0;
    end else begin
      prev_in <= irq_in;
      pend    <= (pend & ~clr) | rise;
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Presents a frozen masked pending snapshot to the priority encoder and clears on ack.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned IDX_W = idx_width(N_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_ctrl_if.slave  bus
);

  irq_state_t       state;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mpend;
  logic [N_SRC-1:0] ack_sel;
  logic [N_SRC-1:0] clr;
  logic             ack_legal;
  logic [N_SRC-1:0] vec_q;
  logic             valid_q;
  logic             err_q;

  // One-hot decode of ack_idx; out-of-range indices decode to zero.
  always_comb begin
    ack_sel = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      ack_sel[i] = (bus.ack_idx == IDX_W'(i));
    end
  end

  assign ack_legal = |(ack_sel & vec_q);
  assign clr       = (state == REQ && bus.irq_ack && ack_legal) ? ack_sel : '0;
  assign mpend     = pend & bus.irq_mask;

  edge_capture #(.N_SRC(N_SRC)) u_edge_capture (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (bus.irq_in),
    .clr    (clr),
    .pend   (pend)
  );

  // Snapshot/handshake FSM: IDLE loads, REQ holds until ack, GAP deasserts one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.irq_ack) err_q <= 1'b1;
          if (|mpend) begin
            vec_q   <= mpend;
            valid_q <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            err_q   <= ~ack_legal;
            vec_q   <= '0;
            valid_q <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (bus.irq_ack) err_q <= 1'b1;
          vec_q   <= '0;
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          vec_q   <= '0;
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.irq_vec   = vec_q;
  assign bus.irq_valid = valid_q;
  assign bus.pend      = pend;
  assign bus.ack_err   = err_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: directed scenarios then random traffic vs a reference model.
module tb_irq_pending_ctrl;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  irq_pending_ctrl_if #(.N_SRC(N)) bus ();

  irq_pending_ctrl #(.N_SRC(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] pend;
    logic [3:0] vec;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: service phases described as "waiting", "presenting", "quiet".
  localparam int PH_WAIT = 0;
  localparam int PH_SHOW = 1;
  localparam int PH_QUIET = 2;

  bit [3:0] m_pend;
  bit [3:0] m_last_in;
  bit [3:0] m_shown;
  bit       m_valid;
  bit       m_err;
  int       m_phase;

  task automatic step(input logic [3:0] in_v, input logic [3:0] mask_v,
                      input logic ack_v, input logic [1:0] idx_v, input logic rst_v);
    bit [3:0] newly;
    int       serviced;
    @(posedge clk);
    #2;
    bus.irq_in   = in_v;
    bus.irq_mask = mask_v;
    bus.irq_ack  = ack_v;
    bus.ack_idx  = idx_v;
    rst_n        = rst_v;

    if (!rst_v) begin
      m_pend = '0; m_last_in = 4'hF; m_shown = '0;
      m_valid = 0; m_err = 0; m_phase = PH_WAIT;
    end else begin
      newly = '0;
      for (int s = 0; s < N; s++) newly[s] = in_v[s] && !m_last_in[s];
      m_last_in = in_v;
      serviced = -1;
      m_err = 0;
      if (m_phase == PH_WAIT) begin
        m_err = ack_v;
        if ((m_pend & mask_v) != 0) begin
          m_shown = m_pend & mask_v;
          m_valid = 1;
          m_phase = PH_SHOW;
        end
      end else if (m_phase == PH_SHOW) begin
        if (ack_v) begin
          if (int'(idx_v) < N && m_shown[idx_v]) serviced = int'(idx_v);
          else m_err = 1;
          m_shown = '0;
          m_valid = 0;
          m_phase = PH_QUIET;
        end
      end else begin
        m_err = ack_v;
        m_phase = PH_WAIT;
      end
      for (int s = 0; s < N; s++) begin
        if (newly[s]) m_pend[s] = 1;
        else if (s == serviced) m_pend[s] = 0;
      end
    end
    q.push_back('{pend: m_pend, vec: m_shown, valid: m_valid, err: m_err});
  endtask

  // Monitor: each cycle compares the registered outputs with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (bus.pend !== e.pend || bus.irq_vec !== e.vec ||
            bus.irq_valid !== e.valid || bus.ack_err !== e.err) begin
          fails++;
          $display("FAIL outputs cyc %0d: got pend=%b vec=%b valid=%b err=%b, expected pend=%b vec=%b valid=%b err=%b",
                   cyc, bus.pend, bus.irq_vec, bus.irq_valid, bus.ack_err,
                   e.pend, e.vec, e.valid, e.err);
        end
      end
    end
  end

  initial begin
    logic [3:0] rin, rmask;
    int drain;
    rst_n        = 1'b0;
    bus.irq_in   = 4'b0110;
    bus.irq_mask = 4'hF;
    bus.irq_ack  = 1'b0;
    bus.ack_idx  = 2'd0;

    // Reset with lines already high, then release: no false edge.
    repeat (3) step(4'b0110, 4'hF, 0, 0, 0);
    repeat (5) step(4'b0110, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 1);

    // Single source 2, legal ack.
    step(4'b0100, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 1, 2, 1);
    repeat (2) step(4'b0000, 4'hF, 0, 0, 1);

    // Sources 3 and 0 together; ack 3 then 0.
    step(4'b1001, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 1, 3, 1);
    repeat (2) step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 1, 0, 1);
    repeat (2) step(4'b0000, 4'hF, 0, 0, 1);

    // Wrong index ack, then correct one after re-presentation.
    step(4'b0100, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 1, 1, 1);
    repeat (2) step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 1, 2, 1);
    step(4'b0000, 4'hF, 1, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 1);

    // Masked source 3 held pending, then unmasked.
    step(4'b1000, 4'b0111, 0, 0, 1);
    repeat (3) step(4'b0000, 4'b0111, 0, 0, 1);
    repeat (2) step(4'b0000, 4'b1111, 0, 0, 1);
    step(4'b0000, 4'hF, 1, 3, 1);
    repeat (2) step(4'b0000, 4'hF, 0, 0, 1);

    // New rise on source 1 coincident with its legal ack, then reset during REQ.
    step(4'b0010, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0010, 4'hF, 1, 1, 1);
    step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 1);
    step(4'b0000, 4'hF, 0, 0, 0);
    repeat (2) step(4'b0000, 4'hF, 0, 0, 1);

    // Random traffic.
    rmask = 4'hF;
    for (int k = 0; k < 600; k++) begin
      rin = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rmask = 4'($urandom_range(0, 15));
      step(rin, rmask, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) != 0));
    end

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(posedge clk);
      #3;
      drain++;
    end
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
